// File: rtl/tlatch_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tlatch_drive_ctrl
//  Purpose  : Upstream driver for a level-sensitive T latch. Accepts writes on
//             a valid/ready handshake and sequences t/en as SETUP -> PULSE ->
//             HOLD so t never moves while en is high. Tracks the expected
//             latch q, checks the synchronised q feedback and counts flips.
//  Revision : 1.0  initial release
// ============================================================================
module tlatch_drive_ctrl #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_t,
    output logic             req_ready,
    output logic             t_out,
    output logic             en_out,
    input  logic             q_fb,
    output logic             shadow_q,
    output logic             shadow_valid,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             clr_mismatch,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Longest phase sets the phase counter width
    localparam int c_MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_MAX_CYC = (c_MAX_SP > HOLD_CYC) ? c_MAX_SP : HOLD_CYC;
    localparam int c_PH_W    = $clog2(c_MAX_CYC + 1);

    // The counter is loaded with (length-1) and the phase ends when it reads 0
    localparam logic [c_PH_W-1:0] c_SETUP_LD = c_PH_W'(SETUP_CYC - 1);
    localparam logic [c_PH_W-1:0] c_PULSE_LD = c_PH_W'(PULSE_CYC - 1);
    localparam logic [c_PH_W-1:0] c_HOLD_LD  = c_PH_W'(HOLD_CYC - 1);
    localparam logic [c_PH_W-1:0] c_PH_ONE   = c_PH_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_PH_W-1:0]   r_phase;
    logic                r_req_ready;
    logic                r_t_out;
    logic                r_en_out;
    logic                r_shadow_q;
    logic                r_shadow_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_mismatch;
    logic [CNT_W-1:0]    r_toggle_cnt;
    logic                r_sync1;
    logic                r_sync2;

    logic                w_phase_last;
    logic                w_new_q;
    logic                w_flip;
    logic                w_q_diff;

    assign w_phase_last = (r_phase == '0);
    // Value the latch will hold once en is pulsed with the current t
    assign w_new_q      = ~r_t_out;
    // Only writes after the first one can count as a change of q
    assign w_flip       = r_shadow_valid & (w_new_q != r_shadow_q);
    assign w_q_diff     = r_sync2 ^ r_shadow_q;

    // Two-flop synchroniser for the asynchronous latch feedback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= q_fb;
            r_sync2 <= r_sync1;
        end
    end

    // Write sequencer with registered latch drive, status and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= '0;
            r_req_ready    <= 1'b1;
            r_t_out        <= 1'b0;
            r_en_out       <= 1'b0;
            r_shadow_q     <= 1'b0;
            r_shadow_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_mismatch     <= 1'b0;
            r_toggle_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            // A clear is overridden below when a new mismatch lands on the same edge
            if (clr_mismatch) begin
                r_mismatch <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_t_out     <= req_t;
                        r_state     <= ST_SETUP;
                        r_phase     <= c_SETUP_LD;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_phase_last) begin
                        r_state        <= ST_PULSE;
                        r_phase        <= c_PULSE_LD;
                        r_en_out       <= 1'b1;
                        r_shadow_q     <= w_new_q;
                        r_shadow_valid <= 1'b1;
                        if (w_flip) begin
                            r_toggle_cnt <= r_toggle_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_phase <= r_phase - c_PH_ONE;
                    end
                end
                ST_PULSE: begin
                    if (w_phase_last) begin
                        r_state  <= ST_HOLD;
                        r_phase  <= c_HOLD_LD;
                        r_en_out <= 1'b0;
                    end else begin
                        r_phase <= r_phase - c_PH_ONE;
                    end
                end
                ST_HOLD: begin
                    if (w_phase_last) begin
                        r_state     <= ST_IDLE;
                        r_phase     <= '0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        if (w_q_diff) begin
                            r_mismatch <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase - c_PH_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_phase     <= '0;
                    r_en_out    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign t_out        = r_t_out;
    assign en_out       = r_en_out;
    assign shadow_q     = r_shadow_q;
    assign shadow_valid = r_shadow_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign mismatch     = r_mismatch;
    assign toggle_cnt   = r_toggle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tlatch_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlatch_drive_ctrl
//  Purpose  : Self-checking bench for tlatch_drive_ctrl. A behavioural model
//             derived from per-write timing offsets predicts every output on
//             every cycle; directed sequences pin key values with literals and
//             a randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlatch_drive_ctrl;

    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 2;
    localparam int L = S + P + H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_t = 1'b0;
    logic       clr_mismatch = 1'b0;
    logic       q_fb;

    logic       req_ready, t_out, en_out, shadow_q, shadow_valid, busy, done, mismatch;
    logic [7:0] toggle_cnt;
    logic       d2_req_ready, d2_t_out, d2_en_out, d2_shadow_q, d2_shadow_valid;
    logic       d2_busy, d2_done, d2_mismatch;
    logic [1:0] d2_toggle_cnt;

    // Behavioural T latch plus an optional stuck value on the feedback path
    logic latch_q = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;
    always @(en_out or t_out) begin
        if (en_out === 1'b1) latch_q = ~t_out;
    end
    assign q_fb = force_en ? force_val : latch_q;

    always #5 clk = ~clk;

    tlatch_drive_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_t(req_t),
        .req_ready(req_ready), .t_out(t_out), .en_out(en_out), .q_fb(q_fb),
        .shadow_q(shadow_q), .shadow_valid(shadow_valid), .busy(busy), .done(done),
        .mismatch(mismatch), .clr_mismatch(clr_mismatch), .toggle_cnt(toggle_cnt)
    );

    tlatch_drive_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_t(req_t),
        .req_ready(d2_req_ready), .t_out(d2_t_out), .en_out(d2_en_out), .q_fb(q_fb),
        .shadow_q(d2_shadow_q), .shadow_valid(d2_shadow_valid), .busy(d2_busy),
        .done(d2_done), .mismatch(d2_mismatch), .clr_mismatch(clr_mismatch),
        .toggle_cnt(d2_toggle_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    // Model state: acceptance cycle of the write in flight, values it carries
    int m_acc = -1;
    bit m_t = 1'b0, m_sh = 1'b0, m_sv = 1'b0, m_mis = 1'b0, m_done = 1'b0, m_ready = 1'b1;
    int m_cnt = 0;
    bit rst_prev = 1'b0, clr_prev = 1'b0;
    int last_acc = -1;
    bit want_force_en = 1'b0, want_force_val = 1'b0;
    bit qhist [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model to the current cycle and compare every output
    task automatic model_and_compare();
        int  j;
        bit  e_busy, e_en;
        if (!rst_prev) begin
            m_acc = -1; m_t = 1'b0; m_sh = 1'b0; m_sv = 1'b0;
            m_cnt = 0; m_mis = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (clr_prev) m_mis = 1'b0;
            if (m_acc >= 0) begin
                j = cyc - m_acc;
                if (j == S + 1) begin
                    if (m_sv && ((!m_t) != m_sh)) m_cnt++;
                    m_sh = !m_t;
                    m_sv = 1'b1;
                end
                if (j == L + 1) begin
                    m_done = 1'b1;
                    // feedback seen two edges late through the synchroniser
                    if (qhist[m_acc + L - 2] != m_sh) m_mis = 1'b1;
                    m_acc = -1;
                end
            end
        end
        e_busy  = (m_acc >= 0);
        j       = cyc - m_acc;
        e_en    = e_busy && (j >= S + 1) && (j <= S + P);
        m_ready = !e_busy;
        chk("req_ready",    32'(req_ready),    32'(m_ready));
        chk("t_out",        32'(t_out),        32'(m_t));
        chk("en_out",       32'(en_out),       32'(e_en));
        chk("shadow_q",     32'(shadow_q),     32'(m_sh));
        chk("shadow_valid", 32'(shadow_valid), 32'(m_sv));
        chk("busy",         32'(busy),         32'(e_busy));
        chk("done",         32'(done),         32'(m_done));
        chk("mismatch",     32'(mismatch),     32'(m_mis));
        chk("toggle_cnt",   32'(toggle_cnt),   32'(m_cnt % 256));
        chk("cnt2_toggle",  32'(d2_toggle_cnt), 32'(m_cnt % 4));
        chk("cnt2_status",
            32'({d2_req_ready, d2_t_out, d2_en_out, d2_shadow_q, d2_shadow_valid, d2_busy, d2_done, d2_mismatch}),
            32'({m_ready, m_t, e_en, m_sh, m_sv, e_busy, m_done, m_mis}));
    endtask

    // One clock cycle: check at the falling edge, then drive this cycle's inputs
    task automatic step(input bit v, input bit t, input bit clr, input bit rn);
        @(negedge clk);
        cyc++;
        model_and_compare();
        req_valid    = v;
        req_t        = t;
        clr_mismatch = clr;
        rst_n        = rn;
        force_en     = want_force_en;
        force_val    = want_force_val;
        #1;
        qhist[cyc] = q_fb;
        if (rn && v && m_ready) begin
            m_acc    = cyc;
            m_t      = t;
            last_acc = cyc;
        end
        clr_prev = clr;
        rst_prev = rn;
    endtask

    // Present a request until accepted, then run it through to its done cycle
    task automatic do_write(input bit t, input bit clr_last, output int a);
        a = -1;
        for (int k = 0; k < 40 && a < 0; k++) begin
            step(1'b1, t, 1'b0, 1'b1);
            if (last_acc == cyc) a = cyc;
        end
        if (a < 0) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout cycle=%0d got=not_accepted expected=accepted", cyc);
        end else begin
            while (cyc < a + L + 1) step(1'b0, t, (clr_last && (cyc + 1 == a + L)), 1'b1);
        end
    endtask

    initial begin : main
        int a, nd, idx;
        int dcyc [0:3];
        bit ts [0:3];
        int cexp [0:4];
        bit pending, pt, rn;

        // 1: reset held for two cycles
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_rst_ready", 32'(req_ready), 32'd1);
        chk("lit_rst_en",    32'(en_out),    32'd0);
        chk("lit_rst_cnt",   32'(toggle_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 2: single write of t=0 with a well-behaved latch
        a = -1;
        for (int k = 0; k < 10 && a < 0; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (last_acc == cyc) a = cyc;
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (cyc == a + 1 || cyc == a + 4) chk("lit_en_low", 32'(en_out), 32'd0);
            if (cyc == a + 2 || cyc == a + 3) chk("lit_en_high", 32'(en_out), 32'd1);
            if (cyc == a + 6) begin
                chk("lit_done",     32'(done),       32'd1);
                chk("lit_shadow_q", 32'(shadow_q),   32'd1);
                chk("lit_first_cnt", 32'(toggle_cnt), 32'd0);
                chk("lit_no_mis",   32'(mismatch),   32'd0);
            end
        end

        // 3: back-to-back writes 0,1,0,0 with valid held
        ts = '{1'b0, 1'b1, 1'b0, 1'b0};
        idx = 0; nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            step(idx < 4, (idx < 4) ? ts[idx] : 1'b0, 1'b0, 1'b1);
            if (last_acc == cyc) idx++;
            if (done === 1'b1) begin dcyc[nd] = cyc; nd++; end
        end
        chk("lit_b2b_dones", 32'(nd), 32'd4);
        chk("lit_b2b_cnt", 32'(toggle_cnt), 32'd2);
        for (int i = 0; i < 3; i++) chk("lit_b2b_spacing", 32'(dcyc[i+1] - dcyc[i]), 32'd6);

        // 4: stuck feedback raises a sticky mismatch; clear; clear loses to set
        want_force_en = 1'b1; want_force_val = 1'b0;
        do_write(1'b0, 1'b0, a);
        chk("lit_mis_set", 32'(mismatch), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_mis_sticky", 32'(mismatch), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_mis_clr", 32'(mismatch), 32'd0);
        do_write(1'b0, 1'b1, a);
        chk("lit_mis_set_wins", 32'(mismatch), 32'd1);
        want_force_en = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 5: reset asserted during PULSE
        a = -1;
        for (int k = 0; k < 10 && a < 0; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (last_acc == cyc) a = cyc;
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_pulse_before_rst", 32'(en_out), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_rst_mid_en",    32'(en_out),       32'd0);
        chk("lit_rst_mid_t",     32'(t_out),        32'd0);
        chk("lit_rst_mid_ready", 32'(req_ready),    32'd1);
        chk("lit_rst_mid_sv",    32'(shadow_valid), 32'd0);

        // 6: alternating writes wrap the 2-bit counter
        cexp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            do_write(i[0], 1'b0, a);
            chk("lit_cnt2_seq", 32'(d2_toggle_cnt), 32'(cexp[i]));
        end

        // Randomized traffic: held requests, clears, stuck feedback, resets
        pending = 1'b0; pt = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (!pending && ($urandom_range(0, 2) == 0)) begin
                pending = 1'b1;
                pt = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) begin
                want_force_en  = 1'($urandom_range(0, 1));
                want_force_val = 1'($urandom_range(0, 1));
            end
            rn = ($urandom_range(0, 199) != 0);
            step(pending, pt, ($urandom_range(0, 15) == 0), rn);
            if (last_acc == cyc) pending = 1'b0;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
